// File: rtl/serial_pkg.sv
// serial_pkg: constants and state encoding shared by the serial framing transmitter and receiver
package serial_pkg;
    localparam logic [7:0] MATCH_DEF = 8'hA5;
    localparam int HEAD_BITS = 8;
    localparam int BODY_BITS = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, BODY = 2'd2} state_t;
endpackage

// File: rtl/xmit_shifter.sv
// xmit_shifter: 16-bit parallel-load MSB-first shift register driving the serial line
module xmit_shifter #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic        clock,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic [15:0] load_val_i,
    output logic        serial_o
);
    logic [15:0] sreg_q, sreg_d;
    // load a frame, shift one bit, or park the line bit at the idle level
    always_comb sreg_d = load_i ? load_val_i : shift_i ? {sreg_q[14:0], 1'b0} : {IDLE_LEVEL, sreg_q[14:0]};
    // frame register; its MSB is the registered line output
    always_ff @(posedge clock) sreg_q <= sreg_d;
    assign serial_o = sreg_q[15];
endmodule

// File: rtl/xmit.sv
// xmit: serial framing transmitter, sends MATCH header then data byte MSB first
module xmit
    import serial_pkg::*;
#(
    parameter logic [7:0] MATCH      = MATCH_DEF,
    parameter logic       IDLE_LEVEL = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       writing,
    output logic       ready,
    output logic       overrun,
    output logic       busy,
    output logic       data_out
);
    localparam logic [2:0] HEAD_LAST = 3'(HEAD_BITS - 1);
    localparam logic [2:0] BODY_LAST = 3'(BODY_BITS - 1);
    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [7:0] hbuf_q, hbuf_d;
    logic       ready_q, ready_d, overrun_q, overrun_d, busy_q, busy_d;
    logic       head_end, body_end, load, shift, accept;
    // FSM state and bit counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end
    // next state: a full buffer starts a frame from IDLE or chains one at end of BODY
    always_comb begin
        head_end = state_q == HEAD && count_q == HEAD_LAST;
        body_end = state_q == BODY && count_q == BODY_LAST;
        load     = !reset && !ready_q && (state_q == IDLE || body_end);
        shift    = !reset && !load && state_q != IDLE && !body_end;
        state_d  = load ? HEAD : head_end ? BODY : body_end ? IDLE : state_q;
        count_d  = state_q == IDLE ? 3'd0 : count_q + 3'd1;
    end
    // handshake outputs: accept frees on load, rejected writes set the sticky overrun
    always_comb begin
        accept    = writing && ready_q;
        hbuf_d    = accept ? data_in : hbuf_q;
        ready_d   = accept ? 1'b0 : load ? 1'b1 : ready_q;
        overrun_d = accept ? 1'b0 : writing ? 1'b1 : overrun_q;
        busy_d    = state_d != IDLE;
    end
    // holding buffer and handshake flags
    always_ff @(posedge clock) begin
        hbuf_q <= hbuf_d;
        if (reset) begin
            ready_q   <= 1'b1;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end
    xmit_shifter #(.IDLE_LEVEL(IDLE_LEVEL)) u_shifter (
        .clock     (clock),
        .load_i    (load),
        .shift_i   (shift),
        .load_val_i({MATCH, hbuf_q}),
        .serial_o  (data_out)
    );
    assign ready   = ready_q;
    assign overrun = overrun_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_xmit.sv
// tb_xmit: randomized and directed checks of xmit against a queue-based line model
module tb_xmit;
    localparam logic [7:0] MATCH = 8'hA5;
    localparam logic       IDLE_LEVEL = 1'b0;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       writing = 1'b0;
    logic       ready, overrun, busy, data_out;
    int checks = 0;
    int failures = 0;

    xmit #(.MATCH(MATCH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .writing (writing),
        .ready   (ready),
        .overrun (overrun),
        .busy    (busy),
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    logic       m_q[$];
    logic [7:0] m_sent[$];
    logic       m_full = 1'b0;
    logic [7:0] m_buf = 8'h00;
    logic       m_ovr = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_out = IDLE_LEVEL;
    wire  [3:0] exp_v = {!m_full, m_ovr, m_busy, m_out};
    wire  [3:0] obs_v = {ready, overrun, busy, data_out};

    logic [7:0] rx[$];
    logic [7:0] win = 8'h00;
    logic [7:0] body = 8'h00;
    logic       in_body = 1'b0;
    int         nbits = 0;

    // reference receiver: hunt for the header, then collect 8 body bits
    always @(negedge clock) begin
        if (reset) begin
            win = 8'h00;
            in_body = 1'b0;
            nbits = 0;
        end else if (in_body) begin
            body = {body[6:0], data_out};
            nbits++;
            if (nbits == 8) begin
                rx.push_back(body);
                in_body = 1'b0;
                win = 8'h00;
            end
        end else begin
            win = {win[6:0], data_out};
            if (win == MATCH) begin
                in_body = 1'b1;
                nbits = 0;
            end
        end
    end

    // one clock edge for DUT and line model; the model treats a frame as a 16-bit queue
    task automatic step(input logic r, input logic w, input logic [7:0] d);
        logic       pre_full;
        logic [15:0] frame;
        reset = r;
        writing = w;
        data_in = d;
        @(posedge clock);
        if (r) begin
            m_q.delete();
            m_full = 1'b0;
            m_ovr = 1'b0;
            m_busy = 1'b0;
            m_out = IDLE_LEVEL;
        end else begin
            pre_full = m_full;
            if (m_q.size() == 0 && pre_full) begin
                frame = {MATCH, m_buf};
                for (int i = 15; i >= 0; i--) m_q.push_back(frame[i]);
                m_sent.push_back(m_buf);
                m_full = 1'b0;
            end
            if (m_q.size() > 0) begin
                m_out = m_q.pop_front();
                m_busy = 1'b1;
            end else begin
                m_out = IDLE_LEVEL;
                m_busy = 1'b0;
            end
            if (w && !pre_full) begin
                m_buf = d;
                m_full = 1'b1;
                m_ovr = 1'b0;
            end else if (w) begin
                m_ovr = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hFF);
        checks++;
        if (obs_v !== 4'b1000) begin
            failures++;
            $display("FAIL reset_state obs=%b exp=%b", obs_v, 4'b1000);
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (obs_v !== exp_v) begin
            failures++;
            $display("FAIL reset_release obs=%b exp=%b", obs_v, exp_v);
        end
    endtask

    task automatic test_single;
        logic [15:0] cap = '0;
        int nb = 0;
        rx.delete();
        step(1'b0, 1'b1, 8'h3C);
        for (int c = 2; c <= 18; c++) begin
            step(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL single_cycle%0d obs=%b exp=%b", c, obs_v, exp_v);
            end
            if (c <= 17) cap = {cap[14:0], data_out};
            nb += int'(busy);
        end
        checks++;
        if (cap !== 16'b1010_0101_0011_1100) begin
            failures++;
            $display("FAIL single_bits obs=%h exp=%h", cap, 16'hA53C);
        end
        checks++;
        if (nb != 16 || data_out !== IDLE_LEVEL) begin
            failures++;
            $display("FAIL single_busy obs=%0d/%b exp=16/%b", nb, data_out, IDLE_LEVEL);
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (rx.size() != 1 || rx[0] !== 8'h3C) begin
            failures++;
            $display("FAIL single_loopback obs=%0d bytes exp=1 byte 3c", rx.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] cap = '0;
        rx.delete();
        step(1'b0, 1'b1, 8'h11);
        for (int c = 2; c <= 35; c++) begin
            step(1'b0, c == 3, 8'h22);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL b2b_cycle%0d obs=%b exp=%b", c, obs_v, exp_v);
            end
            if (c <= 33) cap = {cap[30:0], data_out};
        end
        checks++;
        if (cap !== 32'hA511A522 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stream obs=%h ovr=%b exp=a511a522 ovr=0", cap, overrun);
        end
        checks++;
        if (rx.size() != 2 || rx[0] !== 8'h11 || rx[1] !== 8'h22) begin
            failures++;
            $display("FAIL b2b_loopback obs=%0d bytes exp=2 bytes 11,22", rx.size());
        end
    endtask

    task automatic test_overrun;
        rx.delete();
        step(1'b0, 1'b1, 8'hAA);
        for (int c = 2; c <= 36; c++) begin
            step(1'b0, c == 3 || c == 4, c == 3 ? 8'hBB : 8'hCC);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL ovr_cycle%0d obs=%b exp=%b", c, obs_v, exp_v);
            end
            if (c == 4) begin
                checks++;
                if (overrun !== 1'b1) begin
                    failures++;
                    $display("FAIL ovr_set obs=%b exp=1", overrun);
                end
            end
        end
        checks++;
        if (rx.size() != 2 || rx[0] !== 8'hAA || rx[1] !== 8'hBB || overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_data obs=%0d bytes ovr=%b exp=2 bytes aa,bb ovr=1", rx.size(), overrun);
        end
        step(1'b0, 1'b1, 8'h5A);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear obs=%b exp=0", overrun);
        end
        for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_match_body;
        rx.delete();
        step(1'b0, 1'b1, 8'hA5);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL matchbody_cycle%0d obs=%b exp=%b", c, obs_v, exp_v);
            end
        end
        checks++;
        if (rx.size() != 1 || rx[0] !== 8'hA5 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL matchbody_loopback obs=%0d bytes exp=1 byte a5", rx.size());
        end
    endtask

    task automatic test_reset_mid;
        rx.delete();
        step(1'b0, 1'b1, 8'hF0);
        for (int c = 2; c <= 13; c++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if (obs_v !== 4'b1000) begin
            failures++;
            $display("FAIL midreset_state obs=%b exp=%b", obs_v, 4'b1000);
        end
        step(1'b0, 1'b1, 8'h0F);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, 8'h00);
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL midreset_cycle%0d obs=%b exp=%b", c, obs_v, exp_v);
            end
        end
        checks++;
        if (rx.size() != 1 || rx[0] !== 8'h0F) begin
            failures++;
            $display("FAIL midreset_loopback obs=%0d bytes exp=1 byte 0f", rx.size());
        end
    endtask

    task automatic test_random;
        int bad = 0;
        rx.delete();
        m_sent.delete();
        for (int c = 0; c < 440; c++) begin
            step(1'b0, c < 400 && $urandom_range(0, 3) == 0, 8'($urandom));
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL random_cycle%0d obs=%b exp=%b", c, obs_v, exp_v);
            end
        end
        if (rx.size() != m_sent.size()) bad++;
        else foreach (rx[i]) if (rx[i] !== m_sent[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL random_loopback obs=%0d bytes exp=%0d bytes", rx.size(), m_sent.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_match_body();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
